// File: rtl/reaction_test_sequencer_if.sv
// Button inputs and result/indicator outputs of the reaction-time game controller.
// The master drives the buttons. The slave is the sequencer.
interface reaction_test_sequencer_if;
    logic        start_btn;
    logic        react_btn;
    logic        stim_led;
    logic        busy;
    logic        result_valid;
    logic [13:0] result_ms;
    logic        false_start;
    logic        timeout;
    logic [2:0]  state;

    modport master (
        output start_btn, react_btn,
        input  stim_led, busy, result_valid, result_ms, false_start, timeout, state
    );

    modport slave (
        input  start_btn, react_btn,
        output stim_led, busy, result_valid, result_ms, false_start, timeout, state
    );
endinterface

// File: rtl/reaction_test_sequencer.sv
// Reaction-time game controller.
// After a start press it waits a random delay, lights the stimulus, then times the react press in ms.
module reaction_test_sequencer #(
    parameter int CLKS_PER_MS  = 100000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_MS       = 9999
) (
    input logic                        clk,
    input logic                        rst,
    reaction_test_sequencer_if.slave   bus
);
    localparam int PRE_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

    if (RAND_BITS < 1 || RAND_BITS > 16) begin : g_bad_rand_bits
        $error("RAND_BITS must be in 1..16");
    end
    if (MIN_DELAY_MS < 1 || MIN_DELAY_MS + (1 << RAND_BITS) - 1 >= 65536) begin : g_bad_delay
        $error("MIN_DELAY_MS + 2**RAND_BITS - 1 must fit in 16 bits and MIN_DELAY_MS must be >= 1");
    end
    if (MAX_MS < 1 || MAX_MS > 16383) begin : g_bad_max
        $error("MAX_MS must fit in 14 bits");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_STIM = 3'd2,
        S_DONE = 3'd3,
        S_FOUL = 3'd4,
        S_TOUT = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [15:0]      delay_cnt_q, delay_cnt_d;
    logic [13:0]      ms_cnt_q, ms_cnt_d;
    logic [13:0]      result_ms_q, result_ms_d;
    logic             result_valid_q, result_valid_d;
    logic             false_start_q, false_start_d;
    logic             timeout_q, timeout_d;
    logic             stim_led_q, stim_led_d;
    logic             start_btn_q, start_btn_d;
    logic             react_btn_q, react_btn_d;
    logic             start_rise_q, start_rise_d;
    logic             react_rise_q, react_rise_d;
    logic             ms_tick;

    assign ms_tick = (presc_q == PRE_W'(CLKS_PER_MS - 1));

    always_comb begin
        state_d        = state_q;
        delay_cnt_d    = delay_cnt_q;
        ms_cnt_d       = ms_cnt_q;
        result_ms_d    = result_ms_q;
        result_valid_d = result_valid_q;
        false_start_d  = false_start_q;
        timeout_d      = timeout_q;

        // Rises are registered so each lasts exactly one cycle, one cycle after the press.
        start_btn_d  = bus.start_btn;
        react_btn_d  = bus.react_btn;
        start_rise_d = bus.start_btn & ~start_btn_q;
        react_rise_d = bus.react_btn & ~react_btn_q;

        // Galois right-shift form of x^16+x^14+x^13+x^11; nonzero seed keeps it out of the zero state.
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

        case (state_q)
            S_IDLE, S_DONE, S_FOUL, S_TOUT: begin
                if (start_rise_q) begin
                    delay_cnt_d    = 16'(MIN_DELAY_MS) + 16'(lfsr_q[RAND_BITS-1:0]);
                    ms_cnt_d       = 14'd0;
                    result_valid_d = 1'b0;
                    false_start_d  = 1'b0;
                    timeout_d      = 1'b0;
                    state_d        = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ms_tick) begin
                    delay_cnt_d = delay_cnt_q - 16'd1;
                end
                if (react_rise_q) begin
                    false_start_d = 1'b1;
                    state_d       = S_FOUL;
                end else if (ms_tick && delay_cnt_q == 16'd1) begin
                    state_d = S_STIM;
                end
            end
            S_STIM: begin
                if (ms_tick) begin
                    ms_cnt_d = ms_cnt_q + 14'd1;
                end
                // The react press wins a tie with the timeout tick; it captures the pre-increment count.
                if (react_rise_q) begin
                    result_ms_d    = ms_cnt_q;
                    result_valid_d = 1'b1;
                    state_d        = S_DONE;
                end else if (ms_tick && ms_cnt_q == 14'(MAX_MS - 1)) begin
                    result_ms_d    = 14'(MAX_MS);
                    result_valid_d = 1'b1;
                    timeout_d      = 1'b1;
                    state_d        = S_TOUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        stim_led_d = (state_d == S_STIM);

        // Every state entry restarts the millisecond phase.
        if (state_d != state_q || ms_tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            lfsr_q         <= 16'hACE1;
            presc_q        <= '0;
            delay_cnt_q    <= 16'd0;
            ms_cnt_q       <= 14'd0;
            result_ms_q    <= 14'd0;
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
            timeout_q      <= 1'b0;
            stim_led_q     <= 1'b0;
            start_btn_q    <= 1'b0;
            react_btn_q    <= 1'b0;
            start_rise_q   <= 1'b0;
            react_rise_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            presc_q        <= presc_d;
            delay_cnt_q    <= delay_cnt_d;
            ms_cnt_q       <= ms_cnt_d;
            result_ms_q    <= result_ms_d;
            result_valid_q <= result_valid_d;
            false_start_q  <= false_start_d;
            timeout_q      <= timeout_d;
            stim_led_q     <= stim_led_d;
            start_btn_q    <= start_btn_d;
            react_btn_q    <= react_btn_d;
            start_rise_q   <= start_rise_d;
            react_rise_q   <= react_rise_d;
        end
    end

    assign bus.stim_led     = stim_led_q;
    assign bus.busy         = (state_q == S_WAIT) || (state_q == S_STIM);
    assign bus.result_valid = result_valid_q;
    assign bus.result_ms    = result_ms_q;
    assign bus.false_start  = false_start_q;
    assign bus.timeout      = timeout_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_reaction_test_sequencer.sv
// Bench for reaction_test_sequencer: an elapsed-time reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_reaction_test_sequencer;
    localparam int CLKS  = 10;
    localparam int MIN   = 5;
    localparam int RB    = 3;
    localparam int MAXMS = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reaction_test_sequencer_if bus_if ();

    reaction_test_sequencer #(
        .CLKS_PER_MS (CLKS),
        .MIN_DELAY_MS(MIN),
        .RAND_BITS   (RB),
        .MAX_MS      (MAXMS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the state and time elapsed in it give every output.
    int          cyc = 0;
    int          m_st = 0;
    int          m_enter = 0;
    int          m_d = 0;
    int          m_res = 0;
    bit          m_valid = 0, m_fs = 0, m_to = 0;
    bit          m_srise = 0, m_rrise = 0, m_sprev = 0, m_rprev = 0;
    logic [15:0] m_lfsr = 16'h0;
    bit          chk_en = 0;

    always @(posedge clk) begin
        int el;
        int nst;
        el  = cyc - m_enter;
        nst = m_st;
        if (rst) begin
            nst = 0; m_res = 0; m_valid = 0; m_fs = 0; m_to = 0;
            m_srise = 0; m_rrise = 0; m_sprev = 0; m_rprev = 0;
            m_lfsr = 16'hACE1;
            m_st = 0;
            m_enter = cyc + 1;
        end else begin
            case (m_st)
                1: begin
                    if (m_rrise) begin nst = 4; m_fs = 1; end
                    else if (el == CLKS * m_d - 1) nst = 2;
                end
                2: begin
                    if (m_rrise) begin m_res = el / CLKS; m_valid = 1; nst = 3; end
                    else if (el == CLKS * MAXMS - 1) begin m_res = MAXMS; m_valid = 1; m_to = 1; nst = 5; end
                end
                default: begin
                    if (m_srise) begin
                        nst = 1;
                        m_d = MIN + int'(m_lfsr % (1 << RB));
                        m_valid = 0; m_fs = 0; m_to = 0;
                    end
                end
            endcase
            if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
            else           m_lfsr = m_lfsr >> 1;
            m_srise = bus_if.start_btn && !m_sprev;
            m_rrise = bus_if.react_btn && !m_rprev;
            m_sprev = bus_if.start_btn;
            m_rprev = bus_if.react_btn;
            if (nst != m_st) m_enter = cyc + 1;
            m_st = nst;
        end
        cyc++;
    end

    int wait_entries = 0;
    int prev_state = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", int'(bus_if.state), m_st);
            check("stim_led", int'(bus_if.stim_led), int'(m_st == 2));
            check("busy", int'(bus_if.busy), int'(m_st == 1 || m_st == 2));
            check("result_valid", int'(bus_if.result_valid), int'(m_valid));
            check("result_ms", int'(bus_if.result_ms), m_res);
            check("false_start", int'(bus_if.false_start), int'(m_fs));
            check("timeout", int'(bus_if.timeout), int'(m_to));
            if (bus_if.state == 3'd1 && prev_state != 1) wait_entries++;
            prev_state = int'(bus_if.state);
        end
    end

    // Returns at the negedge of the start_rise cycle with the LFSR value seen in that cycle.
    task automatic press_start(output int r, output int c0);
        bus_if.start_btn = 1'b1;
        @(negedge clk);
        bus_if.start_btn = 1'b0;
        r  = int'(m_lfsr % (1 << RB));
        c0 = cyc;
    endtask

    task automatic wait_state(input int s, output int n);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (int'(bus_if.state) == s) begin
                n = i;
                return;
            end
        end
        n_vec++;
        n_bad++;
        $display("FAIL wait_state_%0d: got no entry within 400 cycles, expected entry", s);
    endtask

    initial begin
        int r, c0, n, d;
        bus_if.start_btn = 1'b0;
        bus_if.react_btn = 1'b0;

        // Reset defaults
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", int'(bus_if.state), 0);
        check("rst_stim", int'(bus_if.stim_led), 0);
        check("rst_busy", int'(bus_if.busy), 0);
        check("rst_valid", int'(bus_if.result_valid), 0);
        check("rst_result", int'(bus_if.result_ms), 0);
        check("rst_fs", int'(bus_if.false_start), 0);
        check("rst_to", int'(bus_if.timeout), 0);
        check("rst_lfsr", int'(dut.lfsr_q), 16'hACE1);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (7) @(negedge clk);

        // Normal run: react 73 cycles after stimulus -> 7 ms
        press_start(r, c0);
        d = MIN + r;
        wait_state(2, n);
        n = cyc - c0;
        check("stim_delay_within_1", int'(n >= 10 * d - 1 && n <= 10 * d + 1), 1);
        check("stim_led_on", int'(bus_if.stim_led), 1);
        repeat (73) @(negedge clk);
        bus_if.react_btn = 1'b1;
        @(negedge clk);
        check("valid_not_yet", int'(bus_if.result_valid), 0);
        @(negedge clk);
        bus_if.react_btn = 1'b0;
        check("run_valid", int'(bus_if.result_valid), 1);
        check("run_result", int'(bus_if.result_ms), 7);
        check("run_state", int'(bus_if.state), 3);
        check("run_stim_off", int'(bus_if.stim_led), 0);

        // False start during WAIT, then restart clears it
        repeat (5) @(negedge clk);
        press_start(r, c0);
        repeat (20) @(negedge clk);
        bus_if.react_btn = 1'b1;
        @(negedge clk);
        bus_if.react_btn = 1'b0;
        @(negedge clk);
        check("foul_fs", int'(bus_if.false_start), 1);
        check("foul_state", int'(bus_if.state), 4);
        check("foul_valid", int'(bus_if.result_valid), 0);
        check("foul_result_held", int'(bus_if.result_ms), 7);
        repeat (3) @(negedge clk);
        press_start(r, c0);
        d = MIN + r;
        @(negedge clk);
        check("restart_fs", int'(bus_if.false_start), 0);
        check("restart_state", int'(bus_if.state), 1);

        // React rise on the WAIT expiry cycle resolves to FOUL
        repeat (10 * d - 2) @(negedge clk);
        bus_if.react_btn = 1'b1;
        @(negedge clk);
        bus_if.react_btn = 1'b0;
        check("race_still_wait", int'(bus_if.state), 1);
        @(negedge clk);
        check("race_wait_foul", int'(bus_if.state), 4);
        check("race_wait_nostim", int'(bus_if.stim_led), 0);

        // React rise on the tick cycle with 4 ms counted captures 4
        repeat (3) @(negedge clk);
        press_start(r, c0);
        wait_state(2, n);
        repeat (48) @(negedge clk);
        bus_if.react_btn = 1'b1;
        @(negedge clk);
        bus_if.react_btn = 1'b0;
        @(negedge clk);
        check("race_stim_result", int'(bus_if.result_ms), 4);
        check("race_stim_state", int'(bus_if.state), 3);

        // Timeout: 200 cycles after STIM entry
        repeat (3) @(negedge clk);
        press_start(r, c0);
        wait_state(2, n);
        wait_state(5, n);
        check("tout_cycles", n, 200);
        check("tout_result", int'(bus_if.result_ms), 20);
        check("tout_flag", int'(bus_if.timeout), 1);
        check("tout_valid", int'(bus_if.result_valid), 1);

        // Start held high: exactly one WAIT entry
        wait_entries = 0;
        bus_if.start_btn = 1'b1;
        repeat (400) @(negedge clk);
        bus_if.start_btn = 1'b0;
        check("held_wait_entries", wait_entries, 1);
        check("held_final_state", int'(bus_if.state), 5);

        // Start presses in WAIT/STIM are ignored, then reset mid-STIM
        repeat (3) @(negedge clk);
        press_start(r, c0);
        d = MIN + r;
        repeat (10) @(negedge clk);
        bus_if.start_btn = 1'b1;
        @(negedge clk);
        bus_if.start_btn = 1'b0;
        wait_state(2, n);
        n = cyc - c0;
        check("ign_stim_delay_within_1", int'(n >= 10 * d - 1 && n <= 10 * d + 1), 1);
        repeat (5) @(negedge clk);
        bus_if.start_btn = 1'b1;
        @(negedge clk);
        bus_if.start_btn = 1'b0;
        @(negedge clk);
        check("ign_stim_state", int'(bus_if.state), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", int'(bus_if.state), 0);
        check("midrst_stim", int'(bus_if.stim_led), 0);
        check("midrst_result", int'(bus_if.result_ms), 0);
        check("midrst_lfsr", int'(dut.lfsr_q), 16'hACE1);
        repeat (5) @(negedge clk);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/reaction_test_sequencer.md
Name: reaction_test_sequencer

Overview:
Top-level game controller for the reaction-time tester. It waits for a start press, then holds off for a pseudo-random delay and lights the stimulus LED. It then measures the time to the react press in milliseconds and reports the result, a false start or a timeout. It sits between the synchronised/debounced button inputs and the display/LED output logic of tt_um_DelosReyesJordan_HDL.

Parameters:
CLKS_PER_MS, 100000, clock cycles per 1 ms tick (100 MHz clk); benches use 10
MIN_DELAY_MS, 1000, fixed part of the pre-stimulus delay in ms
RAND_BITS, 11, number of LFSR bits added to the delay (0..2^RAND_BITS-1 ms)
MAX_MS, 9999, reaction count ceiling; reaching it is a timeout

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
start_btn  in  1  start button, already synchronised and debounced, active-high
react_btn  in  1  react button, already synchronised and debounced, active-high
stim_led  out  1  stimulus light, high only in STIM
busy  out  1  high in WAIT or STIM
result_valid  out  1  result_ms holds a completed measurement
result_ms  out  14  measured reaction time in ms, saturates at MAX_MS
false_start  out  1  react pressed before stimulus
timeout  out  1  no react press before MAX_MS
state  out  3  current state encoding, for debug/display

Behaviour:
- Reset values: state=IDLE(0), every output 0, result_ms=0, LFSR=16'hACE1, prescaler=0, counters=0, edge registers=0.
- Edge detect: registered copies of start_btn and react_btn. start_rise/react_rise = btn & ~btn_q. Each rise lasts 1 cycle, 1 cycle after the input goes high. A held button gives no further rises.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It free-runs every cycle, including in IDLE, so human timing seeds the delay. It never reaches 0.
- Prescaler: counts 0..CLKS_PER_MS-1. ms_tick is high on the wrap cycle. It clears to 0 on every state entry.
- States and encoding: IDLE=0, WAIT=1, STIM=2, DONE=3, FOUL=4, TOUT=5.
- IDLE/DONE/FOUL/TOUT, on start_rise:
  - delay_cnt <= MIN_DELAY_MS + LFSR[RAND_BITS-1:0];
  - clear ms_cnt, result_valid, false_start and timeout; hold result_ms at its old value;
  - next state WAIT.
- WAIT:
  - each ms_tick decrements delay_cnt;
  - when ms_tick arrives with delay_cnt==1, next state is STIM;
  - react_rise: next state FOUL, false_start<=1;
  - react_rise and expiry in the same cycle resolve to FOUL.
- STIM:
  - stim_led=1 (registered, high for the entire STIM state);
  - each ms_tick increments ms_cnt;
  - react_rise: result_ms<=ms_cnt (value before any same-cycle increment), result_valid<=1, next state DONE;
  - ms_tick with ms_cnt==MAX_MS-1: result_ms<=MAX_MS, result_valid<=1, timeout<=1, next state TOUT;
  - react_rise wins over timeout in the same cycle.
- start_rise is ignored in WAIT and STIM.
- A react_rise outside WAIT/STIM is ignored.
- Latency: result_valid/false_start/timeout assert 1 cycle after react_rise, i.e. 2 cycles after the react_btn rising edge.
- Result outputs hold until the next start_rise or rst.
- rst mid-operation returns to IDLE next edge with all reset values. stim_led drops in that cycle.
- Width: ms_cnt and result_ms are 14 bits. delay_cnt is 16 bits. The sum MIN_DELAY_MS+2^RAND_BITS-1 must be < 65536 (elaboration check).

Test Plan:
1. Reset defaults (CLKS_PER_MS=10, MIN_DELAY_MS=5, RAND_BITS=3): assert rst 3 cycles -> all outputs 0, state=0; LFSR=16'hACE1.
2. Normal run: pulse start; record LFSR[2:0]=r at the start_rise cycle; expect STIM exactly (5+r)*10 cycles (+/-1) later. Press react 73 cycles after stim_led rises -> result_ms=7, result_valid=1 on cycle +2, state=3, stim_led=0.
3. False start: start, press react during WAIT -> false_start=1, state=4, stim_led never high, result_valid=0. Press start again -> false_start clears, state=1.
4. Timeout (MAX_MS=20): start, never react -> 200 cycles after STIM entry, result_ms=20, timeout=1, result_valid=1, state=5.
5. Same-cycle races: react_rise on the WAIT expiry cycle -> FOUL. react_rise on the ms_tick cycle in STIM with ms_cnt=4 -> result_ms=4. Start held high continuously -> only one WAIT entry.
6. rst mid-STIM -> next cycle state=0, stim_led=0, result_ms=0. start_rise during WAIT/STIM -> no state change, delay unaffected.
